gpr_mp: RTL and testbench
=========================

# gpr_mp

Parametrised multi-port general-purpose register file with integrated scoreboard. It is the next generation of the core GPR block and supports configurable width, depth, and read/write port counts. It adds write-to-read bypass, per-register pending tracking for issue-stage hazard detection, and a post-reset zeroing sweep. It sits between decode/issue (read and scoreboard ports) and the writeback stage(s) (write ports).

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits (32 or 64)
- NB_REGS, 32, register count (power of two, ≥4); register 0 is hardwired zero
- NB_READ, 2, read port count (1..4)
- NB_WRITE, 1, write port count (1..2)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value
- ADDR_W, $clog2(NB_REGS), derived, not overridable

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- ready_o  out  1  1 = sweep done, block accepts traffic
- rs_addr_i  in  NB_READ*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rs_data_o  out  NB_READ*DATA_WIDTH  read data, combinational
- rs_busy_o  out  NB_READ  pending bit of each addressed register, combinational
- wb_valid_i  in  NB_WRITE  write enables
- wb_addr_i  in  NB_WRITE*ADDR_W  write addresses
- wb_data_i  in  NB_WRITE*DATA_WIDTH  write data
- iss_valid_i  in  1  issue of an instruction with destination iss_rd_i
- iss_rd_i  in  ADDR_W  destination register being marked pending

## Operation
- Two-state FSM: SWEEP and RUN.
- On rst_i = 1, the FSM enters SWEEP immediately, the sweep counter goes to 0, and all pending bits clear. Array contents are not reset asynchronously.
- SWEEP: each rising edge writes mem[cnt] = 0 and increments cnt. After the edge that writes cnt = NB_REGS-1, the FSM moves to RUN. wb_* and iss_* are ignored.
- In SWEEP: ready_o = 0, rs_data_o = 0, rs_busy_o = 0.
- RUN: ready_o = 1. The FSM never leaves RUN except on reset.
- Write: on a rising edge with wb_valid_i[j] = 1 and wb_addr_i[j] != 0, mem[addr] <= data. Writes to address 0 are dropped.
- Write conflict: both ports valid to the same nonzero address → port 1 wins.
- Read: rs_data_o[k] = 0 if rs_addr_i[k] = 0. Otherwise:
  - with BYPASS = 1, the highest-index valid write port matching the address supplies the data;
  - else the stored mem value.
- Scoreboard, one bit per register; bit 0 is constant 0.
  - Set: iss_valid_i with iss_rd_i != 0.
  - Clear: any valid write to that address.
  - Same register set and cleared on one edge → set wins, so the bit ends at 1 (the new producer is outstanding).
  - rs_busy_o[k] = pending[rs_addr_i[k]] & ~(BYPASS & matching valid write this cycle).
- Setting an already pending bit leaves it at 1; no counting. Clearing a non-pending bit is harmless.

## Timing
- Reset values: ready_o = 0, rs_data_o = 0, rs_busy_o = 0, all pending bits = 0.
- Sweep length:
  - rst_i deasserted before edge E1 → registers 0..NB_REGS-1 are written on edges E1..E_NB_REGS.
  - ready_o rises after edge E_NB_REGS, i.e. 32 edges for the default depth.
- Reset asserted mid-sweep or mid-RUN: outputs go to reset values immediately. The sweep restarts from 0 after deassertion.
- Write latency: the value is visible from storage in the cycle after the edge. With BYPASS = 1 it is also visible combinationally in the same cycle.
- Scoreboard latency: rs_busy_o reflects an issue starting the cycle after the issuing edge.
- Read paths, bypass, and busy are purely combinational, with no added pipeline stage.

## Test plan
- Sweep: preload mem with 0xDEADBEEF via backdoor, pulse rst_i, read all 32 addresses once ready_o rises → all 0. ready_o must be 0 for exactly 32 edges after deassertion.
- Write/read and x0: write 0x12345678 to x5 and 0xFFFFFFFF to x0 → x5 reads 0x12345678 next cycle, x0 reads 0.
- Bypass: BYPASS = 1, x7 holds 0x1; drive wb x7 = 0xA5A5A5A5 and read x7 in the same cycle → rs_data_o = 0xA5A5A5A5 before the edge. With BYPASS = 0, it reads 0x1 before the edge.
- Conflict: NB_WRITE = 2, both ports write x3 (port0 = 0x11, port1 = 0x22) → x3 = 0x22.
- Scoreboard:
  - Issue x9 → rs_busy_o = 1 from the next cycle.
  - Writeback x9 with a simultaneous issue of x9 → busy stays 1.
  - A lone writeback x9 → busy 0 after the edge.
  - Issue x0 → never busy.
- Reset mid-operation: pending x4, ready_o = 1; assert rst_i between edges → ready_o, rs_data_o, and rs_busy_o go to 0 immediately. After release, the full sweep repeats and x4 is not busy.

Source files
------------

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file with write bypass, issue scoreboard
// and a post-reset zeroing sweep of the storage array.
module gpr_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_REGS    = 32,
  parameter int unsigned NB_READ    = 2,
  parameter int unsigned NB_WRITE   = 1,
  parameter bit          BYPASS     = 1'b1,
  localparam int unsigned ADDR_W    = $clog2(NB_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  output logic                           ready_o,
  input  logic [NB_READ*ADDR_W-1:0]      rs_addr_i,
  output logic [NB_READ*DATA_WIDTH-1:0]  rs_data_o,
  output logic [NB_READ-1:0]             rs_busy_o,
  input  logic [NB_WRITE-1:0]            wb_valid_i,
  input  logic [NB_WRITE*ADDR_W-1:0]     wb_addr_i,
  input  logic [NB_WRITE*DATA_WIDTH-1:0] wb_data_i,
  input  logic                           iss_valid_i,
  input  logic [ADDR_W-1:0]              iss_rd_i
);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0]  mem [NB_REGS];
  logic [NB_REGS-1:0]     pend_q, pend_d;
  logic                   run;

  // State register and sweep counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SWEEP) cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  // Next state: leave the sweep once the last register has been cleared
  always_comb begin
    state_d = state_q;
    if (state_q == SWEEP && cnt_q == ADDR_W'(NB_REGS - 1)) state_d = RUN;
  end

  // FSM outputs
  always_comb begin
    run     = (state_q == RUN);
    ready_o = run;
  end

  // Storage array; later write ports override earlier ones on address conflict
  always_ff @(posedge clk_i) begin
    if (!run) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NB_WRITE; j++) begin
        if (wb_valid_i[j] && wb_addr_i[j*ADDR_W +: ADDR_W] != '0)
          mem[wb_addr_i[j*ADDR_W +: ADDR_W]] <= wb_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Scoreboard update: writebacks clear, a same-edge issue re-sets the bit
  always_comb begin
    pend_d = pend_q;
    if (run) begin
      for (int j = 0; j < NB_WRITE; j++) begin
        if (wb_valid_i[j]) pend_d[wb_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_valid_i) pend_d[iss_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Combinational read ports with optional forwarding of in-flight writes
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int k = 0; k < NB_READ; k++) begin
      if (run && rs_addr_i[k*ADDR_W +: ADDR_W] != '0) begin
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[rs_addr_i[k*ADDR_W +: ADDR_W]];
        rs_busy_o[k] = pend_q[rs_addr_i[k*ADDR_W +: ADDR_W]];
        if (BYPASS) begin
          for (int j = 0; j < NB_WRITE; j++) begin
            if (wb_valid_i[j] &&
                wb_addr_i[j*ADDR_W +: ADDR_W] == rs_addr_i[k*ADDR_W +: ADDR_W]) begin
              rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wb_data_i[j*DATA_WIDTH +: DATA_WIDTH];
              rs_busy_o[k] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: a two-write-port bypassing instance alongside a
// single-write-port instance without bypass, driven from shared stimulus.
module tb_gpr_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [2*AW-1:0] rs_addr;
  logic [1:0]      wb_valid;
  logic [2*AW-1:0] wb_addr;
  logic [2*DW-1:0] wb_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;

  logic            rdy_a, rdy_b;
  logic [2*DW-1:0] data_a, data_b;
  logic [1:0]      busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  gpr_mp #(.DATA_WIDTH(32), .NB_REGS(32), .NB_READ(2), .NB_WRITE(2), .BYPASS(1'b1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .ready_o(rdy_a),
    .rs_addr_i(rs_addr), .rs_data_o(data_a), .rs_busy_o(busy_a),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd)
  );

  gpr_mp #(.DATA_WIDTH(32), .NB_REGS(32), .NB_READ(2), .NB_WRITE(1), .BYPASS(1'b0)) u_nb (
    .clk_i(clk_i), .rst_i(rst_i), .ready_o(rdy_b),
    .rs_addr_i(rs_addr), .rs_data_o(data_b), .rs_busy_o(busy_b),
    .wb_valid_i(wb_valid[0]), .wb_addr_i(wb_addr[AW-1:0]), .wb_data_i(wb_data[DW-1:0]),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges from reset release until ready; expects the full depth
  task automatic sweep(input string tag);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    for (int e = 1; e <= 64 && !done; e++) begin
      @(posedge clk_i); #1;
      if (e == 10) begin
        chk({tag, "_mid_rdy"}, 64'(rdy_a), 64'd0);
        chk({tag, "_mid_data"}, data_a, 64'd0);
      end
      if (rdy_a) begin
        n    = e;
        done = 1'b1;
      end
    end
    chk({tag, "_len"}, 64'(n), 64'd32);
    chk({tag, "_rdy_nb"}, 64'(rdy_b), 64'd1);
  endtask

  initial begin
    rst_i     = 1'b1;
    rs_addr   = {5'd9, 5'd5};
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    #1;
    chk("rst_rdy", 64'(rdy_a), 64'd0);
    chk("rst_data", data_a, 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    sweep("sweep0");

    // Fill every register with a marker so the next sweep has work to do
    for (int a = 1; a < 32; a++) begin
      @(negedge clk_i);
      wb_valid = 2'b01;
      wb_addr  = {5'd0, 5'(a)};
      wb_data  = {32'd0, 32'hDEADBEEF};
    end
    @(negedge clk_i);
    wb_valid = '0;
    rs_addr  = {5'd31, 5'd17};
    #1;
    chk("fill_a", data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("fill_b", data_b[DW-1:0], 64'hDEADBEEF);

    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    sweep("sweep1");
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("swept_a", data_a, 64'd0);
      chk("swept_b", data_b[DW-1:0], 64'd0);
    end

    // Write x5 and attempt x0
    @(negedge clk_i);
    wb_valid = 2'b11;
    wb_addr  = {5'd0, 5'd5};
    wb_data  = {32'hFFFFFFFF, 32'h12345678};
    @(negedge clk_i);
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd7};
    wb_data  = {32'd0, 32'h1};
    rs_addr  = {5'd0, 5'd5};
    #1;
    chk("wr_x5", data_a[DW-1:0], 64'h12345678);
    chk("wr_x0", data_a[2*DW-1:DW], 64'd0);
    chk("wr_x5_nb", data_b[DW-1:0], 64'h12345678);

    // Same-cycle bypass vs stored value
    @(negedge clk_i);
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd7};
    wb_data  = {32'd0, 32'hA5A5A5A5};
    rs_addr  = {5'd0, 5'd7};
    #1;
    chk("byp_on", data_a[DW-1:0], 64'hA5A5A5A5);
    chk("byp_off", data_b[DW-1:0], 64'h1);
    @(negedge clk_i);
    wb_valid = '0;
    #1;
    chk("byp_off_after", data_b[DW-1:0], 64'hA5A5A5A5);

    // Two-port conflict on x3
    wb_valid = 2'b11;
    wb_addr  = {5'd3, 5'd3};
    wb_data  = {32'h22, 32'h11};
    rs_addr  = {5'd0, 5'd3};
    #1;
    chk("conf_byp", data_a[DW-1:0], 64'h22);
    @(negedge clk_i);
    wb_valid = '0;
    #1;
    chk("conf_a", data_a[DW-1:0], 64'h22);
    chk("conf_b", data_b[DW-1:0], 64'h11);

    // Scoreboard on x9
    rs_addr   = {5'd9, 5'd0};
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    #1;
    chk("sb_pre", 64'(busy_a[1]), 64'd0);
    @(negedge clk_i);
    iss_valid = 1'b0;
    #1;
    chk("sb_iss_a", 64'(busy_a[1]), 64'd1);
    chk("sb_iss_b", 64'(busy_b[1]), 64'd1);
    wb_valid  = 2'b01;
    wb_addr   = {5'd0, 5'd9};
    wb_data   = {32'd0, 32'h99};
    iss_valid = 1'b1;
    #1;
    chk("sb_byp_a", 64'(busy_a[1]), 64'd0);
    chk("sb_byp_b", 64'(busy_b[1]), 64'd1);
    @(negedge clk_i);
    wb_valid  = '0;
    iss_valid = 1'b0;
    #1;
    chk("sb_setwin_a", 64'(busy_a[1]), 64'd1);
    chk("sb_setwin_b", 64'(busy_b[1]), 64'd1);
    chk("sb_x9_data", data_a[2*DW-1:DW], 64'h99);
    wb_valid = 2'b01;
    wb_data  = {32'd0, 32'h77};
    @(negedge clk_i);
    wb_valid = '0;
    #1;
    chk("sb_clr_a", 64'(busy_a[1]), 64'd0);
    chk("sb_clr_b", 64'(busy_b[1]), 64'd0);
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    rs_addr   = {5'd0, 5'd9};
    @(negedge clk_i);
    iss_valid = 1'b0;
    #1;
    chk("sb_x0", 64'(busy_a), 64'd0);
    chk("sb_x9_stay", 64'(busy_b[0]), 64'd0);

    // Reset in the middle of RUN with x4 pending
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    @(negedge clk_i);
    iss_valid = 1'b0;
    rs_addr   = {5'd5, 5'd4};
    #1;
    chk("mid_busy", 64'(busy_a), 64'b01);
    chk("mid_rdy", 64'(rdy_a), 64'd1);
    chk("mid_x5", data_a[2*DW-1:DW], 64'h12345678);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_rdy", 64'({rdy_a, rdy_b}), 64'd0);
    chk("arst_data", data_a, 64'd0);
    chk("arst_busy", 64'(busy_a), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    sweep("sweep2");
    chk("post_x4_busy", 64'(busy_a[0]), 64'd0);
    chk("post_x5_data", data_a[2*DW-1:DW], 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
